// File: rtl/vector_alu_seq_pkg.sv
// Shared definitions for the vector ALU sequencer: element-width and state
// encodings, the OP-V major opcode, and the VLMAX helper.
package vector_alu_seq_pkg;

  typedef enum logic [2:0] {
    SEW8  = 3'd0,
    SEW16 = 3'd1,
    SEW32 = 3'd2
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [6:0] OPV_OPCODE = 7'h57;

  // VLMAX = (VLEN << lmul) / SEW, where SEW = 8 << sew.
  function automatic logic [31:0] calc_vlmax(input logic [2:0] sew,
                                             input logic [1:0] lmul,
                                             input int         vlen);
    logic [31:0] group_bits;
    group_bits = 32'(vlen) << lmul;
    return group_bits >> (32'd3 + 32'(sew));
  endfunction

endpackage

// File: rtl/vector_alu_seq_vtail_bemask.sv
// Byte-enable mask for one register of a group: a byte is enabled when the
// element it belongs to lies below vl_eff. any_active flags registers that
// hold at least one active element.
module vtail_bemask
  import vector_alu_seq_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic [2:0]          i_k,
  input  logic [2:0]          i_sew,
  input  logic [31:0]         i_vl_eff,
  output logic [VLEN/8-1:0]   o_wbe,
  output logic                o_any_active
);

  localparam int NB        = VLEN / 8;
  localparam int LOG2_VLEN = $clog2(VLEN);

  // Index of the first element held by register k of the group.
  logic [31:0] base_elem;
  assign base_elem    = (32'(i_k) << LOG2_VLEN) >> (32'd3 + 32'(i_sew));
  assign o_any_active = base_elem < i_vl_eff;

  // Each byte maps to element base + b / (SEW/8).
  always_comb begin
    o_wbe = '0;
    for (int b = 0; b < NB; b++) begin
      o_wbe[b] = (base_elem + (32'(b) >> i_sew)) < i_vl_eff;
    end
  end

endmodule

// File: rtl/vector_alu_seq.sv
// Vector ALU sequencer: accepts one OP-V arithmetic instruction, walks the
// LMUL register group reading both sources, and writes ALU results one cycle
// behind the reads with tail-undisturbed byte enables.
module vector_alu_seq
  import vector_alu_seq_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int NVREG = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [5:0]                i_funct6,
  input  logic [$clog2(NVREG)-1:0]  i_vs1a,
  input  logic [$clog2(NVREG)-1:0]  i_vs2a,
  input  logic [$clog2(NVREG)-1:0]  i_vda,
  input  logic [2:0]                i_sew,
  input  logic [1:0]                i_lmul,
  input  logic [31:0]               i_vl,
  output logic [$clog2(NVREG)-1:0]  o_vrf_ra1,
  output logic [$clog2(NVREG)-1:0]  o_vrf_ra2,
  input  logic [VLEN-1:0]           i_vrf_rd1,
  input  logic [VLEN-1:0]           i_vrf_rd2,
  output logic [VLEN-1:0]           o_alu_a,
  output logic [VLEN-1:0]           o_alu_b,
  output logic [5:0]                o_alu_ctrl,
  output logic [2:0]                o_alu_sew,
  input  logic [VLEN-1:0]           i_alu_result,
  output logic                      o_vrf_we,
  output logic [$clog2(NVREG)-1:0]  o_vrf_wa,
  output logic [VLEN-1:0]           o_vrf_wdata,
  output logic [VLEN/8-1:0]         o_vrf_wbe,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  localparam int AW = $clog2(NVREG);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [5:0]        funct6_q, funct6_d;
  logic [2:0]        sew_q, sew_d;
  logic [1:0]        lmul_q, lmul_d;
  logic [AW-1:0]     vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [31:0]       vl_eff_q, vl_eff_d;
  logic [AW-1:0]     ra1_q, ra1_d, ra2_q, ra2_d;
  logic              we_q, we_d;
  logic [AW-1:0]     wa_q, wa_d;
  logic [VLEN/8-1:0] wbe_q, wbe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [VLEN/8-1:0] mask_wbe;
  logic              mask_any;
  logic [AW-1:0]     grp_mask;
  logic              illegal;
  logic [31:0]       vlmax;
  logic [2:0]        k_last;

  vtail_bemask #(.VLEN(VLEN)) u_bemask (
    .i_k          (k_q),
    .i_sew        (sew_q),
    .i_vl_eff     (vl_eff_q),
    .o_wbe        (mask_wbe),
    .o_any_active (mask_any)
  );

  assign grp_mask = AW'((8'd1 << i_lmul) - 8'd1);
  assign illegal  = (i_sew > SEW32) || (|((i_vs1a | i_vs2a | i_vda) & grp_mask));
  assign vlmax    = calc_vlmax(i_sew, i_lmul, VLEN);
  assign k_last   = 3'((4'd1 << lmul_q) - 4'd1);

  // Next-state logic: issue in IDLE, read walk in RUN, write trails by one.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    funct6_d = funct6_q;
    sew_d    = sew_q;
    lmul_d   = lmul_q;
    vs1_d    = vs1_q;
    vs2_d    = vs2_q;
    vd_d     = vd_q;
    vl_eff_d = vl_eff_q;
    ra1_d    = ra1_q;
    ra2_d    = ra2_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wbe_d    = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          funct6_d = i_funct6;
          sew_d    = i_sew;
          lmul_d   = i_lmul;
          vs1_d    = i_vs1a;
          vs2_d    = i_vs2a;
          vd_d     = i_vda;
          vl_eff_d = (i_vl < vlmax) ? i_vl : vlmax;
          if (illegal) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            k_d     = 3'd0;
            ra1_d   = i_vs1a;
            ra2_d   = i_vs2a;
          end
        end
      end
      ST_RUN: begin
        we_d  = mask_any;
        wa_d  = vd_q + AW'(k_q);
        wbe_d = mask_wbe;
        if (k_q == k_last) begin
          state_d = ST_DRAIN;
        end else begin
          k_d   = k_q + 3'd1;
          ra1_d = vs1_q + AW'(k_q) + AW'(1);
          ra2_d = vs2_q + AW'(k_q) + AW'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      funct6_q <= '0;
      sew_q    <= '0;
      lmul_q   <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      vl_eff_q <= '0;
      ra1_q    <= '0;
      ra2_q    <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wbe_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      funct6_q <= funct6_d;
      sew_q    <= sew_d;
      lmul_q   <= lmul_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      vd_q     <= vd_d;
      vl_eff_q <= vl_eff_d;
      ra1_q    <= ra1_d;
      ra2_q    <= ra2_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wbe_q    <= wbe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_vrf_ra1   = ra1_q;
  assign o_vrf_ra2   = ra2_q;
  assign o_alu_a     = i_vrf_rd1;
  assign o_alu_b     = i_vrf_rd2;
  assign o_alu_ctrl  = funct6_q;
  assign o_alu_sew   = sew_q;
  assign o_vrf_we    = we_q;
  assign o_vrf_wa    = wa_q;
  assign o_vrf_wdata = i_alu_result;
  assign o_vrf_wbe   = wbe_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Scoreboard bench for vector_alu_seq: directed instructions push expected
// writes and done pulses; monitors pop and compare as the DUT presents them.
module tb_vector_alu_seq;

   typedef struct packed {
      logic [5:0]        f6;
      logic [2:0]        sew;
      logic [1:0]        lmul;
      logic [31:0]       vl;
      logic [4:0]        vs1;
      logic [4:0]        vs2;
      logic [4:0]        vd;
      logic              err;
      int                lat;
      logic [7:0][15:0]  wbe;
   } vec_t;

   typedef struct packed {
      int           id;
      int           off;
      logic [4:0]   wa;
      logic [127:0] wdata;
      logic [15:0]  wbe;
   } wexp_t;

   typedef struct packed {
      int   id;
      int   lat;
      logic err;
   } dexp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         iValid;
   logic         oReady;
   logic [5:0]   iFunct6;
   logic [4:0]   iVs1a, iVs2a, iVda;
   logic [2:0]   iSew;
   logic [1:0]   iLmul;
   logic [31:0]  iVl;
   logic [4:0]   vrfRa1, vrfRa2;
   logic [127:0] vrfRd1, vrfRd2;
   logic [127:0] aluA, aluB, aluResult;
   logic [5:0]   aluCtrl;
   logic [2:0]   aluSew;
   logic         vrfWe;
   logic [4:0]   vrfWa;
   logic [127:0] vrfWdata;
   logic [15:0]  vrfWbe;
   logic         oBusy, oDone, oErr;

   int    nVec = 0;
   int    nMiss = 0;
   int    cyc = 0;
   int    issueCount = 0;
   int    acceptCyc[$];
   wexp_t writeQ[$];
   dexp_t doneQ[$];
   vec_t  vecs[8];

   vector_alu_seq #(.VLEN(128), .NVREG(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (iValid),
      .o_ready      (oReady),
      .i_funct6     (iFunct6),
      .i_vs1a       (iVs1a),
      .i_vs2a       (iVs2a),
      .i_vda        (iVda),
      .i_sew        (iSew),
      .i_lmul       (iLmul),
      .i_vl         (iVl),
      .o_vrf_ra1    (vrfRa1),
      .o_vrf_ra2    (vrfRa2),
      .i_vrf_rd1    (vrfRd1),
      .i_vrf_rd2    (vrfRd2),
      .o_alu_a      (aluA),
      .o_alu_b      (aluB),
      .o_alu_ctrl   (aluCtrl),
      .o_alu_sew    (aluSew),
      .i_alu_result (aluResult),
      .o_vrf_we     (vrfWe),
      .o_vrf_wa     (vrfWa),
      .o_vrf_wdata  (vrfWdata),
      .o_vrf_wbe    (vrfWbe),
      .o_busy       (oBusy),
      .o_done       (oDone),
      .o_err        (oErr)
   );

   always #5 clk = ~clk;

   // Fixed register-file contents: every register and lane is distinct.
   function automatic logic [127:0] romVal(input logic [4:0] r);
      logic [127:0] v;
      v = '0;
      for (int j = 0; j < 4; j++) v[j*32 +: 32] = {3'b101, r, 8'(j), 8'hC3, 8'h5A};
      return v;
   endfunction

   // Synchronous-read register file model and a lane ALU that mixes in ctrl/sew.
   always @(posedge clk) begin
      vrfRd1 <= romVal(vrfRa1);
      vrfRd2 <= romVal(vrfRa2);
   end
   assign aluResult = aluA ^ aluB ^ {16{aluSew[1:0], aluCtrl}};

   // Edge counter and accept recorder.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && iValid && oReady) acceptCyc.push_back(cyc);
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nVec++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare each write and each done pulse against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && vrfWe) begin
         if (writeQ.size() == 0) begin
            checkOutput("unexpected write wa", 128'(vrfWa), 128'hFFFF);
         end else begin
            wexp_t e;
            e = writeQ.pop_front();
            checkOutput("write wa", 128'(vrfWa), 128'(e.wa));
            checkOutput("write wbe", 128'(vrfWbe), 128'(e.wbe));
            checkOutput("write wdata", vrfWdata, e.wdata);
            if (e.id < acceptCyc.size())
               checkOutput("write cycle", 128'(cyc), 128'(acceptCyc[e.id] + e.off));
            else
               checkOutput("write before accept", 128'(cyc), 128'(0));
         end
      end
      if (rst_n && oDone) begin
         if (doneQ.size() == 0) begin
            checkOutput("unexpected done", 128'(oDone), 128'(0));
         end else begin
            dexp_t d;
            d = doneQ.pop_front();
            checkOutput("done err", 128'(oErr), 128'(d.err));
            if (d.id < acceptCyc.size())
               checkOutput("done cycle", 128'(cyc), 128'(acceptCyc[d.id] + d.lat));
            else
               checkOutput("done before accept", 128'(cyc), 128'(0));
         end
      end
   end

   function automatic vec_t mk(input logic [5:0] f6, input logic [2:0] sew, input logic [1:0] lmul,
                               input logic [31:0] vl, input logic [4:0] vs1, input logic [4:0] vs2,
                               input logic [4:0] vd, input logic err, input int lat,
                               input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                               input logic [15:0] w3, input logic [15:0] w47);
      vec_t v;
      v.f6 = f6; v.sew = sew; v.lmul = lmul; v.vl = vl;
      v.vs1 = vs1; v.vs2 = vs2; v.vd = vd; v.err = err; v.lat = lat;
      v.wbe[0] = w0; v.wbe[1] = w1; v.wbe[2] = w2; v.wbe[3] = w3;
      for (int k = 4; k < 8; k++) v.wbe[k] = w47;
      return v;
   endfunction

   // Push the expected writes (first 'keep' of them) and optionally the done pulse.
   task automatic pushExpect(input vec_t v, input int keep, input bit wantDone, output int id);
      int nw;
      id = issueCount;
      issueCount++;
      nw = 0;
      for (int k = 0; k < 8; k++) begin
         if (v.wbe[k] != 16'h0 && nw < keep) begin
            wexp_t e;
            logic [4:0] a1, a2;
            a1 = v.vs1 + 5'(k);
            a2 = v.vs2 + 5'(k);
            e.id = id; e.off = k + 1; e.wa = v.vd + 5'(k); e.wbe = v.wbe[k];
            e.wdata = romVal(a1) ^ romVal(a2) ^ {16{v.sew[1:0], v.f6}};
            writeQ.push_back(e);
            nw++;
         end
      end
      if (wantDone) begin
         dexp_t d;
         d.id = id; d.lat = v.lat; d.err = v.err;
         doneQ.push_back(d);
      end
   endtask

   // Drive one instruction and return #1 after the edge that accepts it.
   task automatic applyStimulus(input int idx, input int keep, input bit wantDone,
                                input bit holdValid, output int id);
      vec_t v;
      bit   ok;
      v = vecs[idx];
      @(negedge clk);
      iFunct6 = v.f6; iSew = v.sew; iLmul = v.lmul; iVl = v.vl;
      iVs1a = v.vs1; iVs2a = v.vs2; iVda = v.vd; iValid = 1'b1;
      pushExpect(v, keep, wantDone, id);
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (oReady) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         checkOutput("accept timeout", 128'(oReady), 128'(1));
      end else begin
         @(posedge clk);
         #1;
      end
      if (!holdValid) iValid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         #1;
         if (writeQ.size() == 0 && doneQ.size() == 0 && oReady) return;
      end
      checkOutput("drain timeout", 128'(writeQ.size() + doneQ.size()), 128'(0));
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " ready"}, 128'(oReady), 128'(1));
      checkOutput({tag, " busy"}, 128'(oBusy), 128'(0));
      checkOutput({tag, " done"}, 128'(oDone), 128'(0));
      checkOutput({tag, " err"}, 128'(oErr), 128'(0));
      checkOutput({tag, " we"}, 128'(vrfWe), 128'(0));
      checkOutput({tag, " ra1"}, 128'(vrfRa1), 128'(0));
      checkOutput({tag, " ra2"}, 128'(vrfRa2), 128'(0));
      checkOutput({tag, " wa"}, 128'(vrfWa), 128'(0));
      checkOutput({tag, " wbe"}, 128'(vrfWbe), 128'(0));
   endtask

   initial begin
      int id0, id1, id2;
      //           f6     sew   lmul  vl        vs1    vs2    vd     err   lat  w0        w1        w2        w3        w4..7
      vecs[0] = mk(6'h01, 3'd2, 2'd0, 32'd4,    5'd2,  5'd3,  5'd4,  1'b0, 2, 16'hFFFF, 16'h0,    16'h0,    16'h0,    16'h0);
      vecs[1] = mk(6'h02, 3'd2, 2'd2, 32'd10,   5'd0,  5'd4,  5'd8,  1'b0, 5, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0,    16'h0);
      vecs[2] = mk(6'h03, 3'd0, 2'd1, 32'd0,    5'd2,  5'd4,  5'd6,  1'b0, 3, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0);
      vecs[3] = mk(6'h04, 3'd2, 2'd1, 32'd4,    5'd0,  5'd2,  5'd5,  1'b1, 0, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0);
      vecs[4] = mk(6'h05, 3'd3, 2'd1, 32'd4,    5'd2,  5'd4,  5'd6,  1'b1, 0, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0);
      vecs[5] = mk(6'h06, 3'd2, 2'd3, 32'd1000, 5'd8,  5'd16, 5'd24, 1'b0, 9, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      vecs[6] = mk(6'h07, 3'd1, 2'd1, 32'd11,   5'd10, 5'd12, 5'd14, 1'b0, 3, 16'hFFFF, 16'h003F, 16'h0,    16'h0,    16'h0);
      vecs[7] = mk(6'h08, 3'd0, 2'd0, 32'd5,    5'd1,  5'd7,  5'd3,  1'b0, 2, 16'h001F, 16'h0,    16'h0,    16'h0,    16'h0);

      rst_n = 1'b0; iValid = 1'b0; iFunct6 = '0; iSew = '0; iLmul = '0; iVl = '0;
      iVs1a = '0; iVs2a = '0; iVda = '0;
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(i, 8, 1'b1, 1'b0, id0);
         waitDrain();
      end

      // Abort an LMUL=8 instruction in its 4th RUN cycle: only k=0,1 get written.
      applyStimulus(5, 2, 1'b0, 1'b0, id0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort we", 128'(vrfWe), 128'(0));
      checkOutput("abort busy", 128'(oBusy), 128'(0));
      checkOutput("abort done", 128'(oDone), 128'(0));
      repeat (2) @(posedge clk);
      #1;
      checkResetState("abort");
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort leftover writes", 128'(writeQ.size()), 128'(0));
      applyStimulus(0, 8, 1'b1, 1'b0, id0);
      waitDrain();

      // Back-to-back issue with i_valid held high.
      applyStimulus(0, 8, 1'b1, 1'b1, id1);
      checkOutput("queued ready while busy", 128'(oReady), 128'(0));
      checkOutput("queued busy", 128'(oBusy), 128'(1));
      applyStimulus(6, 8, 1'b1, 1'b0, id2);
      if (id2 < acceptCyc.size())
         checkOutput("queued accept cycle", 128'(acceptCyc[id2]), 128'(acceptCyc[id1] + vecs[0].lat + 2));
      else
         checkOutput("queued accept missing", 128'(acceptCyc.size()), 128'(id2 + 1));
      waitDrain();

      repeat (4) @(negedge clk);
      checkOutput("accept count", 128'(acceptCyc.size()), 128'(issueCount));
      checkOutput("write queue empty", 128'(writeQ.size()), 128'(0));
      checkOutput("done queue empty", 128'(doneQ.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
